// File: rtl/div_unit_if.sv
// Operand/result bundle between EX control and the iterative divider.
// The master side issues requests; the slave side (div_unit) returns results.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_div_op;
    logic [WIDTH-1:0] i_operand_a;
    logic [WIDTH-1:0] i_operand_b;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_div_data;

    modport master (
        output i_start, i_div_op, i_operand_a, i_operand_b,
        input  o_ready, o_busy, o_done, o_div_data
    );

    modport slave (
        input  i_start, i_div_op, i_operand_a, i_operand_b,
        output o_ready, o_busy, o_done, o_div_data
    );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_FAST_PATH_EN to short-circuit divide-by-zero, signed overflow and divide-by-one.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic       i_clk,
    input logic       i_rst_n,
    div_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             rem_sel_q, rem_sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    logic             signed_op;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_shift, diff;
    logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef DIV_FAST_PATH_EN
    logic             fast;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        data_d    = data_q;
        done_d    = 1'b0;

        signed_op = ~bus.i_div_op[0];
        a_abs = (signed_op && bus.i_operand_a[WIDTH-1]) ?
                (~bus.i_operand_a + WIDTH'(1)) : bus.i_operand_a;
        b_abs = (signed_op && bus.i_operand_b[WIDTH-1]) ?
                (~bus.i_operand_b + WIDTH'(1)) : bus.i_operand_b;

        // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, div_q};

        // A zero divisor leaves the all-ones quotient unsigned.
        quo_fix = (neg_quo_q && (div_q != '0)) ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

`ifdef DIV_FAST_PATH_EN
        fast = (bus.i_operand_b == '0) || (bus.i_operand_b == WIDTH'(1)) ||
               (signed_op && (bus.i_operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (bus.i_operand_b == '1));
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    rem_sel_d = bus.i_div_op[1];
                    neg_quo_d = signed_op &
                                (bus.i_operand_a[WIDTH-1] ^ bus.i_operand_b[WIDTH-1]);
                    neg_rem_d = signed_op & bus.i_operand_a[WIDTH-1];
                    quo_d     = a_abs;
                    div_d     = b_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = StCalc;
`ifdef DIV_FAST_PATH_EN
                    // Preload the final magnitudes so StSign applies the usual sign fix.
                    if (fast) begin
                        quo_d   = (bus.i_operand_b == '0) ? '1 : a_abs;
                        rem_d   = (bus.i_operand_b == '0) ? a_abs : '0;
                        state_d = StSign;
                    end
`endif
                end
            end
            StCalc: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                data_d  = rem_sel_q ? rem_fix : quo_fix;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.o_ready    = (state_q == StIdle);
    assign bus.o_busy     = (state_q != StIdle);
    assign bus.o_done     = done_q;
    assign bus.o_div_data = data_q;

endmodule
